// File: rtl/rgb_hue_sequencer_pkg.sv
// Shared types and constants for the RGB hue sequencer: sequencer state,
// segment index type, channel bit positions and the hard-mode colour table.
package rgb_hue_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   typedef logic [2:0] seg_t;

   // Index of the last colour-wheel segment; the wheel has six segments.
   localparam seg_t SEG_LAST = 3'd5;

   // Bit positions inside a {R,G,B} lit mask.
   localparam int CH_R = 2;
   localparam int CH_G = 1;
   localparam int CH_B = 0;

   // Hard-mode colours as {R,G,B} lit masks:
   // red, yellow, green, cyan, blue, magenta.
   localparam logic [2:0] HARD_LIT [0:5] = '{
      3'b100,
      3'b110,
      3'b010,
      3'b011,
      3'b001,
      3'b101
   };

   // Segment after s, wrapping from the last segment back to 0.
   function automatic seg_t next_seg(input seg_t s);
      return (s == SEG_LAST) ? 3'd0 : s + 3'd1;
   endfunction

   // Lit mask for segment s in hard mode; unused codes stay dark.
   function automatic logic [2:0] hard_lit(input seg_t s);
      if (s <= SEG_LAST) begin
         return HARD_LIT[s];
      end
      return 3'b000;
   endfunction

endpackage

// File: rtl/rgb_hue_sequencer_pwm_channel.sv
// One PWM channel: holds a duty shadow that only changes at the end of a
// PWM period, compares it against the shared counter and drives a
// registered, active-low LED pin.
module pwm_channel
   import rgb_hue_sequencer_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                start,
   input  logic                run,
   input  logic [PWM_BITS-1:0] duty,
   input  logic [PWM_BITS-1:0] cnt,
   output logic                out
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] shadow;

   // Shadow reload at period end plus registered compare (lit when cnt < shadow).
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the shadow is a plain register, not a memory, so it is reset
      // with everything else; a stale duty must never leak into a new run.
      if (rst) begin
         shadow <= '0;
         out    <= 1'b1;
      end else if (clear) begin
         shadow <= '0;
         out    <= 1'b1;
      end else if (start) begin
         // Entry into RUN: first period uses the segment-0 duty directly.
         shadow <= duty;
         out    <= 1'b1;
      end else if (run) begin
         out <= ~(cnt < shadow);
         if (cnt == MAX) begin
            shadow <= duty;
         end
      end
   end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// RGB hue sequencer: walks the board LED through a six-segment colour wheel,
// either as a smooth ramp or as hard colour steps, using three PWM channels
// that share one free-running PWM counter. LED toggles at every segment
// boundary as a heartbeat.
module rgb_hue_sequencer
   import rgb_hue_sequencer_pkg::*;
#(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 1200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       mode,
   output logic       LED,
   output logic       seg_pulse,
   output logic [2:0] seg_idx,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   localparam int                  PS_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAX     = '1;

   seq_state_t          state;
   logic [PS_W-1:0]     prescaler;
   logic [PWM_BITS-1:0] lvl;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                mode_q;

   logic                start;
   logic                run;
   logic                clear;
   logic                tick;

   logic                mode_eff;
   logic [PWM_BITS-1:0] up;
   logic [PWM_BITS-1:0] dn;
   logic [2:0]          lit;
   logic [PWM_BITS-1:0] duty_r;
   logic [PWM_BITS-1:0] duty_g;
   logic [PWM_BITS-1:0] duty_b;

   assign start = (state == IDLE) && en;
   assign run   = (state == RUN) && en;
   assign clear = (state == RUN) && !en;
   assign tick  = (prescaler == PS_LAST);

   // Sequencer FSM: prescaler, level ramp, segment index, heartbeat and PWM counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every register here uses non-blocking assignment so all of them
      // update from the same pre-edge values, exactly like the flops they become.
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         lvl       <= '0;
         pwm_cnt   <= '0;
         seg_idx   <= 3'd0;
         seg_pulse <= 1'b0;
         LED       <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               seg_pulse <= 1'b0;
               if (en) begin
                  state  <= RUN;
                  mode_q <= mode;
               end
            end
            RUN: begin
               if (!en) begin
                  state     <= IDLE;
                  prescaler <= '0;
                  lvl       <= '0;
                  pwm_cnt   <= '0;
                  seg_idx   <= 3'd0;
                  seg_pulse <= 1'b0;
                  LED       <= 1'b0;
               end else begin
                  // All-ones MAX means the counter wraps to 0 on its own.
                  pwm_cnt   <= pwm_cnt + 1'b1;
                  seg_pulse <= 1'b0;
                  if (tick) begin
                     prescaler <= '0;
                     if (lvl == MAX) begin
                        lvl       <= '0;
                        seg_idx   <= next_seg(seg_idx);
                        seg_pulse <= 1'b1;
                        LED       <= ~LED;
                        // Mode only takes effect from the next segment onward.
                        mode_q    <= mode;
                     end else begin
                        lvl <= lvl + 1'b1;
                     end
                  end else begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Target duty per channel from segment, level and the latched mode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      duty_r   = '0;
      duty_g   = '0;
      duty_b   = '0;
      // Before entry the latched mode is stale; use the live input instead.
      mode_eff = (state == IDLE) ? mode : mode_q;
      up       = lvl;
      dn       = MAX - lvl;
      lit      = hard_lit(seg_idx);
      if (mode_eff) begin
         duty_r = lit[CH_R] ? MAX : '0;
         duty_g = lit[CH_G] ? MAX : '0;
         duty_b = lit[CH_B] ? MAX : '0;
      end else begin
         case (seg_idx)
            3'd0: begin
               duty_r = MAX;
               duty_g = up;
            end
            3'd1: begin
               duty_r = dn;
               duty_g = MAX;
            end
            3'd2: begin
               duty_g = MAX;
               duty_b = up;
            end
            3'd3: begin
               duty_g = dn;
               duty_b = MAX;
            end
            3'd4: begin
               duty_r = up;
               duty_b = MAX;
            end
            3'd5: begin
               duty_r = MAX;
               duty_b = dn;
            end
            default: begin
               duty_r = '0;
               duty_g = '0;
               duty_b = '0;
            end
         endcase
      end
   end

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .start (start),
      .run   (run),
      .duty  (duty_r),
      .cnt   (pwm_cnt),
      .out   (RGB_R)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .start (start),
      .run   (run),
      .duty  (duty_g),
      .cnt   (pwm_cnt),
      .out   (RGB_G)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .start (start),
      .run   (run),
      .duty  (duty_b),
      .cnt   (pwm_cnt),
      .out   (RGB_B)
   );

endmodule
